// File: rtl/prom_arbiter.sv
// Round-robin arbiter sharing the single-port boot PROM between CPU fetch (m0) and monitor/loader (m1).
// Optional read timeout abort is enabled by defining PROM_ARB_TIMEOUT_EN.
module prom_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [8:0]  i_m0_addr,
  output logic        o_m0_ack,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [8:0]  i_m1_addr,
  output logic        o_m1_ack,
  output logic [31:0] o_m_data_out,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [8:0]  o_s_addr,
  input  logic [31:0] i_s_data_in,
  input  logic        i_s_ack,
  output logic        o_wr_viol,
  output logic        o_tmo_err
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        r_gnt, w_gnt_nxt;
  logic        r_m0_ack, w_m0_ack_nxt;
  logic        r_m1_ack, w_m1_ack_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_s_stb, w_s_stb_nxt;
  logic [8:0]  r_s_addr, w_s_addr_nxt;
  logic        r_wr_viol, w_wr_viol_nxt;
  logic        r_tmo_err, w_tmo_err_nxt;

  logic        w_sel;
  logic        w_sel_we;
  logic [8:0]  w_sel_addr;
  logic        w_tmo_hit;

  // On a tie the master not granted last time wins; otherwise whichever is strobing.
  assign w_sel      = (i_m0_stb && i_m1_stb) ? ~r_last : i_m1_stb;
  assign w_sel_we   = w_sel ? i_m1_we   : i_m0_we;
  assign w_sel_addr = w_sel ? i_m1_addr : i_m0_addr;

`ifdef PROM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != BUSY)) r_tmo_cnt <= '0;
    else                          r_tmo_cnt <= r_tmo_cnt + CW'(1);
  end

  assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gnt_nxt     = r_gnt;
    w_data_nxt    = r_data;
    w_s_stb_nxt   = r_s_stb;
    w_s_addr_nxt  = r_s_addr;
    w_m0_ack_nxt  = 1'b0;
    w_m1_ack_nxt  = 1'b0;
    w_wr_viol_nxt = 1'b0;
    w_tmo_err_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_m0_stb || i_m1_stb) begin
          w_last_nxt = w_sel;
          w_gnt_nxt  = w_sel;
          if (w_sel_we) begin
            w_m0_ack_nxt  = ~w_sel;
            w_m1_ack_nxt  = w_sel;
            w_wr_viol_nxt = 1'b1;
            w_state_nxt   = ACK;
          end else begin
            w_s_stb_nxt  = 1'b1;
            w_s_addr_nxt = w_sel_addr;
            w_state_nxt  = BUSY;
          end
        end
      end
      BUSY: begin
        // A PROM ack in the terminal cycle takes precedence over the abort.
        if (i_s_ack) begin
          w_data_nxt   = i_s_data_in;
          w_m0_ack_nxt = ~r_gnt;
          w_m1_ack_nxt = r_gnt;
          w_s_stb_nxt  = 1'b0;
          w_state_nxt  = ACK;
        end else if (w_tmo_hit) begin
          w_data_nxt    = '0;
          w_m0_ack_nxt  = ~r_gnt;
          w_m1_ack_nxt  = r_gnt;
          w_tmo_err_nxt = 1'b1;
          w_s_stb_nxt   = 1'b0;
          w_state_nxt   = ACK;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_data    <= '0;
      r_s_stb   <= 1'b0;
      r_s_addr  <= '0;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_wr_viol <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt     <= w_gnt_nxt;
      r_data    <= w_data_nxt;
      r_s_stb   <= w_s_stb_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_m0_ack  <= w_m0_ack_nxt;
      r_m1_ack  <= w_m1_ack_nxt;
      r_wr_viol <= w_wr_viol_nxt;
      r_tmo_err <= w_tmo_err_nxt;
    end
  end

  assign o_m0_ack     = r_m0_ack;
  assign o_m1_ack     = r_m1_ack;
  assign o_m_data_out = r_data;
  assign o_s_stb      = r_s_stb;
  assign o_s_we       = 1'b0;
  assign o_s_addr     = r_s_addr;
  assign o_wr_viol    = r_wr_viol;
  assign o_tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_prom_arbiter.sv
// Self-checking bench for prom_arbiter: PROM model with toggling ack, transaction table,
// hand-written corner sequences and a randomized run against a timing-level reference model.
module tb_prom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [8:0]  m0_addr = '0, m1_addr = '0;
  logic        m0_ack, m1_ack, s_stb, s_we, wr_viol, tmo_err;
  logic [31:0] m_data, s_data;
  logic [8:0]  s_addr;
  logic        s_ack = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] mem [512];
  int          checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  prom_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .o_m0_ack(m0_ack),
    .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .o_m1_ack(m1_ack),
    .o_m_data_out(m_data), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .i_s_data_in(s_data), .i_s_ack(s_ack), .o_wr_viol(wr_viol), .o_tmo_err(tmo_err)
  );

  // PROM: registered data, ack toggles every cycle while strobed
  always @(posedge clk) begin
    s_data <= mem[s_addr];
    if (stall || !s_stb) s_ack <= 1'b0;
    else                 s_ack <= ~s_ack;
  end

  typedef struct {
    logic s0; logic w0; logic [8:0] a0;
    logic s1; logic w1; logic [8:0] a1;
    int exp_m; logic exp_wv; logic [31:0] exp_d;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle_masters;
    m0_stb = 0; m0_we = 0; m0_addr = '0; m1_stb = 0; m1_we = 0; m1_addr = '0;
  endtask

  task automatic do_reset;
    rst = 1; idle_masters(); tick(); tick(); rst = 0;
  endtask

  task automatic wait_ack(input int lim, output int who);
    who = -1;
    for (int c = 0; c < lim && who < 0; c++) begin
      tick();
      if (m0_ack) who = 0;
      else if (m1_ack) who = 1;
    end
  endtask

  int who, t0, n, got, lat, nack;
  logic prev_ack, stb_seen, g_wv;
  logic [31:0] g_d;
  // reference model state for the random run
  int nxt_s, m_last, e_k, e_m, lo, hi, g;
  logic e_wv, ps0, pw0, ps1, pw1;
  logic [31:0] e_d;
  logic [8:0] e_a, pa0, pa1;
  logic [5:0] exp_v, act_v;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[5] = 32'h1234_5678;

    vt[0] = '{1'b1, 1'b0, 9'h005, 1'b0, 1'b0, 9'h000, 0, 1'b0, 32'h1234_5678};
    vt[1] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 9'h010, 1, 1'b1, 32'h0};
    vt[2] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h010, 1, 1'b0, 32'hC0DE_0010};
    vt[3] = '{1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h1FF, 0, 1'b0, 32'hC0DE_0000};
    vt[4] = '{1'b1, 1'b0, 9'h0AA, 1'b1, 1'b0, 9'h1FF, 1, 1'b0, 32'hC0DE_01FF};
    vt[5] = '{1'b1, 1'b1, 9'h033, 1'b1, 1'b0, 9'h044, 0, 1'b1, 32'h0};
    vt[6] = '{1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 9'h000, 0, 1'b0, 32'hC0DE_01FF};
    vt[7] = '{1'b1, 1'b0, 9'h003, 1'b1, 1'b1, 9'h004, 1, 1'b1, 32'h0};

    // reset values
    rst = 1; idle_masters(); tick(); tick();
    chk("reset_outputs", {m0_ack, m1_ack, s_stb, wr_viol, tmo_err, s_we}, 6'b0);
    chk("reset_saddr", {23'b0, s_addr}, 32'h0);
    chk("reset_data", m_data, 32'h0);
    rst = 0;

    // single transactions from idle
    for (int i = 0; i < 8; i++) begin
      chk("vec_sack_idle", {31'b0, s_ack}, 32'h0);
      m0_stb = vt[i].s0; m0_we = vt[i].w0; m0_addr = vt[i].a0;
      m1_stb = vt[i].s1; m1_we = vt[i].w1; m1_addr = vt[i].a1;
      got = -1; lat = 0; stb_seen = 0; g_wv = 0; g_d = '0;
      for (int c = 1; c <= 10 && got < 0; c++) begin
        tick();
        if (s_stb) stb_seen = 1;
        if (m0_ack || m1_ack) begin
          got = m1_ack ? 1 : 0; lat = c; g_wv = wr_viol; g_d = m_data;
        end
      end
      chk("vec_grant", got, vt[i].exp_m);
      chk("vec_latency", lat, vt[i].exp_wv ? 1 : 3);
      chk("vec_wr_viol", {31'b0, g_wv}, {31'b0, vt[i].exp_wv});
      if (vt[i].exp_wv) chk("vec_write_no_sstb", {31'b0, stb_seen}, 32'h0);
      else              chk("vec_data", g_d, vt[i].exp_d);
      idle_masters(); tick();
      chk("vec_pulse_drop", {30'b0, m0_ack, m1_ack}, 32'h0);
      tick();
    end

    // both held continuously: alternate grants, 4-cycle spacing, 1-cycle pulses
    do_reset();
    m0_stb = 1; m0_addr = 9'h001; m1_stb = 1; m1_addr = 9'h002;
    n = 0; prev_ack = 0; t0 = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (prev_ack) chk("fair_pulse_width", {30'b0, m0_ack, m1_ack}, 32'h0);
      prev_ack = m0_ack | m1_ack;
      if (m0_ack || m1_ack) begin
        chk("fair_order", {30'b0, m0_ack, m1_ack}, (n % 2 == 1) ? 32'h1 : 32'h2);
        chk("fair_data", m_data, (n % 2 == 1) ? 32'hC0DE_0002 : 32'hC0DE_0001);
        if (n > 0) chk("fair_spacing", cyc - t0, 4);
        t0 = cyc; n++;
      end
    end
    chk("fair_count", n, 4);
    idle_masters(); tick();
    chk("fair_last_pulse", {30'b0, m0_ack, m1_ack}, 32'h0);
    tick();

    // back-to-back reads from m0
    m0_stb = 1; m0_addr = 9'h000;
    wait_ack(12, who);
    chk("b2b_who0", who, 0);
    chk("b2b_data0", m_data, 32'hC0DE_0000);
    chk("b2b_sack0", {31'b0, s_ack}, 32'h0);
    t0 = cyc; m0_addr = 9'h1FF;
    wait_ack(12, who);
    chk("b2b_who1", who, 0);
    chk("b2b_spacing", cyc - t0, 4);
    chk("b2b_data1", m_data, 32'hC0DE_01FF);
    chk("b2b_sack1", {31'b0, s_ack}, 32'h0);
    idle_masters(); tick(); tick();

    // PROM never acks
    stall = 1; m0_stb = 1; m0_addr = 9'h007; t0 = cyc;
`ifdef PROM_ARB_TIMEOUT_EN
    wait_ack(12, who);
    chk("tmo_who", who, 0);
    chk("tmo_latency", cyc - t0, 5);
    chk("tmo_data", m_data, 32'h0);
    chk("tmo_err", {31'b0, tmo_err}, 32'h1);
    idle_masters(); tick();
    chk("tmo_pulse_drop", {29'b0, m0_ack, m1_ack, tmo_err}, 32'h0);
`else
    nack = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m0_ack || m1_ack || tmo_err) nack++;
    end
    chk("stall_no_ack", nack, 0);
    chk("stall_sstb_held", {31'b0, s_stb}, 32'h1);
`endif
    idle_masters(); stall = 0;

    // reset while BUSY drops the strobe at once, no ack
    rst = 1; tick();
    chk("rst_sstb_drop", {31'b0, s_stb}, 32'h0);
    chk("rst_no_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
    tick(); rst = 0;
    m1_stb = 1; m1_addr = 9'h0AA;
    tick();
    chk("rst2_granted", {31'b0, s_stb}, 32'h1);
    rst = 1; tick();
    chk("rst2_sstb_drop", {31'b0, s_stb}, 32'h0);
    chk("rst2_no_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
    tick(); rst = 0;
    wait_ack(12, who);
    chk("rst2_after_who", who, 1);
    chk("rst2_after_data", m_data, 32'hC0DE_00AA);
    idle_masters(); tick();

    // randomized traffic against a timing-level model
    do_reset();
    nxt_s = 0; m_last = 1; e_k = -1; e_m = 0; lo = -1; hi = -2;
    e_wv = 0; e_d = '0; e_a = '0;
    for (int k = 0; k < 3000; k++) begin
      ps0 = m0_stb; pw0 = m0_we; pa0 = m0_addr;
      ps1 = m1_stb; pw1 = m1_we; pa1 = m1_addr;
      tick();
      if (k >= nxt_s && (ps0 || ps1)) begin
        g = (ps0 && ps1) ? 1 - m_last : (ps1 ? 1 : 0);
        m_last = g; e_m = g;
        if (g == 1 ? pw1 : pw0) begin
          e_k = k; e_wv = 1; nxt_s = k + 2;
        end else begin
          e_a = (g == 1) ? pa1 : pa0;
          e_k = k + 2; e_wv = 0; e_d = mem[e_a]; nxt_s = k + 4; lo = k; hi = k + 1;
        end
      end
      exp_v = {(e_k == k && e_m == 0), (e_k == k && e_m == 1), (e_k == k && e_wv),
               (k >= lo && k <= hi), 1'b0, 1'b0};
      act_v = {m0_ack, m1_ack, wr_viol, s_stb, s_we, tmo_err};
      chk("rnd_ctl", {26'b0, act_v}, {26'b0, exp_v});
      if (e_k == k && !e_wv) chk("rnd_data", m_data, e_d);
      if (k >= lo && k <= hi) chk("rnd_saddr", {23'b0, s_addr}, {23'b0, e_a});
      if (m0_stb && m0_ack) m0_stb = 0;
      else if (!m0_stb && $urandom_range(0, 2) == 0) begin
        m0_stb = 1; m0_we = ($urandom_range(0, 3) == 0); m0_addr = 9'($urandom_range(0, 511));
      end
      if (m1_stb && m1_ack) m1_stb = 0;
      else if (!m1_stb && $urandom_range(0, 2) == 0) begin
        m1_stb = 1; m1_we = ($urandom_range(0, 3) == 0); m1_addr = 9'($urandom_range(0, 511));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
